mix_columns_unit: RTL and testbench
===================================

Name: mix_columns_unit

Overview:
- Parametrised MixColumns engine for the AES datapath, succeeding the fixed single-cycle forward-only stage.
- Supports three modes per block:
  - forward MixColumns, for encryption rounds;
  - InvMixColumns, for decryption rounds;
  - bypass, for the final round.
- Processes COLS_PER_CYCLE columns per cycle behind valid/ready handshakes.
- Latency is fixed and independent of data and mode, to avoid a timing side-channel. The block sits between ShiftRows and AddRoundKey in the round pipeline.

Parameters:
- COLS_PER_CYCLE, default 4: columns transformed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.
- BEATS, derived as 4/COLS_PER_CYCLE: busy cycles per block (not overridable).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  input block valid
- in_ready  out  1  block can accept input
- in_mode  in  2  00 = forward, 01 = inverse, 10 = bypass, 11 = bypass
- in_state  in  128  input state; column c occupies bits [c*32 +: 32]
- out_valid  out  1  out_state holds a finished block
- out_ready  in  1  downstream accepts the block
- out_state  out  128  result state, same layout as in_state

Behaviour:
- **Reset:** clk and rst are named as in the codebase. Reset is synchronous and active-high. While rst=1 at a rising edge:
  - FSM goes to IDLE;
  - out_valid=0, out_state=0, internal column counter=0, latched mode=00, working buffer=0.
  - in_ready is combinational and therefore 0 while in reset.
  - Reset mid-block discards the block; no partial output is ever flagged valid.
- **Column byte order:** within a column, row0 = [c*32+24 +: 8], row1 = [+16], row2 = [+8], row3 = [c*32 +: 8].
- **Forward matrix** (rows): [2 3 1 1] [1 2 3 1] [1 1 2 3] [3 1 1 2].
- **Inverse matrix** (rows): [e b d 9] [9 e b d] [d 9 e b] [b d 9 e].
- **GF(2^8) arithmetic:** polynomial x^8+x^4+x^3+x+1. xtime(x) = (x<<1) ^ (x[7] ? 8'h1b : 0). Multiplies by 9, b, d and e are built from xtime chains and XOR only; no lookup tables.
- **Bypass:** copies the column unchanged, but uses the same cycle count as the other modes.
- **FSM states:** IDLE, BUSY, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid&&in_ready: latch in_state into the working buffer, latch in_mode, set counter=0, go to BUSY.
- **BUSY:**
  - in_ready=0, out_valid=0.
  - Each cycle, transform COLS_PER_CYCLE columns starting at column 3 (bits 127:96) and descending, write them into out_state, and advance the counter.
  - After the BEATS-th cycle, go to DONE.
- **DONE:**
  - out_valid=1. out_state is stable and holds all 4 transformed columns.
  - On out_ready=1:
    - if in_valid=1 in the same cycle, accept the new block and go directly to BUSY (back-to-back, with no IDLE bubble);
    - otherwise go to IDLE and drop out_valid.
  - out_ready=0 stalls indefinitely; out_state and out_valid hold.
- **in_ready:** equals (state==IDLE) || (state==DONE && out_ready).
- **Latency:** input handshake at edge t gives out_valid=1 from edge t+BEATS.
  - COLS_PER_CYCLE=4: next cycle.
  - COLS_PER_CYCLE=1: 4 cycles.
  - Maximum throughput is one block per BEATS+1 cycles.
- **Input stability:** in_state and in_mode are sampled only on the accepting edge. Changes afterwards do not affect the block in flight.
- **out_state outside DONE:** its contents are defined only when out_valid=1. During BUSY it holds a mix of new and old columns; downstream must ignore it.
- **Timing independence:** no data-dependent or mode-dependent control path. All modes take exactly BEATS busy cycles.

Test Plan:
- **Forward FIPS-197 columns, COLS_PER_CYCLE=4.** Mode 00, in_state = db135345_f20a225c_01010101_c6c6c6c6. Required: out_state = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid exactly 1 cycle after accept.
- **Inverse round-trip, COLS_PER_CYCLE=1.** Mode 01, in_state = 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8. Required: db135345_f20a225c_d4d4d4d5_2d26314c, with out_valid 4 cycles after accept. Also feed 100 random states forward then inverse and require the original back.
- **Bypass timing, COLS_PER_CYCLE=2.** Mode 10 with any state. Required: out_state equals the input, with latency 2 cycles, identical to mode 00. Mode 11 gives the same result.
- **Backpressure and back-to-back.**
  - Hold out_ready=0 for 5 cycles in DONE: out_state and out_valid hold, and in_ready=0.
  - Then assert out_ready with in_valid=1 in the same cycle: the new block is accepted that cycle and there is no IDLE cycle.
- **Reset mid-operation.** COLS_PER_CYCLE=1, assert rst during the 2nd BUSY cycle. Required: next cycle out_valid=0, out_state=0, in_ready=1. A following block then produces the correct result.
- **Input change after accept.** Change in_state and in_mode during BUSY. Required: the result matches the originally accepted values.

Source files
------------

// File: rtl/mix_columns_unit.sv
// mix_columns_unit: multi-beat AES MixColumns/InvMixColumns/bypass engine behind valid/ready handshakes
module mix_columns_unit #(
  parameter int COLS_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_mode,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);
  localparam int BEATS = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(BEATS - 1);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("mix_columns_unit: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  logic [1:0]   st;
  logic [1:0]   cnt;
  logic [1:0]   mode;
  logic [127:0] work_q;
  logic [127:0] out_next;
  logic         accept;
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gm(input logic [7:0] b, input logic [3:0] k);
    return (k[0] ? b : 8'h00) ^ (k[1] ? xt(b) : 8'h00) ^ (k[2] ? xt(xt(b)) : 8'h00) ^ (k[3] ? xt(xt(xt(b))) : 8'h00);
  endfunction
  function automatic logic [31:0] mix_col(input logic [31:0] c, input logic [1:0] m);
    logic [7:0] a [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) a[i] = c[24-8*i +: 8];
    for (int i = 0; i < 4; i++)
      r[24-8*i +: 8] = m[1] ? a[i] : m[0]
        ? gm(a[i], 4'he) ^ gm(a[(i+1)%4], 4'hb) ^ gm(a[(i+2)%4], 4'hd) ^ gm(a[(i+3)%4], 4'h9)
        : gm(a[i], 4'h2) ^ gm(a[(i+1)%4], 4'h3) ^ a[(i+2)%4] ^ a[(i+3)%4];
    return r;
  endfunction
  assign in_ready  = !rst && (st == IDLE || (st == DONE && out_ready));
  assign out_valid = st == DONE;
  assign accept    = in_valid && in_ready;
  always_comb begin
    out_next = out_state;
    for (int j = 0; j < COLS_PER_CYCLE; j++)
      out_next[(3 - j - COLS_PER_CYCLE * int'(cnt)) * 32 +: 32] =
        mix_col(work_q[(3 - j - COLS_PER_CYCLE * int'(cnt)) * 32 +: 32], mode);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      cnt       <= '0;
      mode      <= '0;
      work_q    <= '0;
      out_state <= '0;
    end else if (accept) begin
      work_q <= in_state;
      mode   <= in_mode;
      cnt    <= '0;
      st     <= BUSY;
    end else if (st == BUSY) begin
      out_state <= out_next;
      cnt       <= cnt + 2'd1;
      st        <= cnt == LAST ? DONE : BUSY;
    end else if (st == DONE && out_ready) begin
      st <= IDLE;
    end
  end
endmodule

// File: tb/tb_mix_columns_unit.sv
// tb_mix_columns_unit: self-checking bench for mix_columns_unit at 1, 2 and 4 columns per cycle
module tb_mix_columns_unit;
  logic         clk = 0;
  logic         rst [3];
  logic         iv [3];
  logic         ir [3];
  logic [1:0]   md [3];
  logic [127:0] is_ [3];
  logic         ov [3];
  logic         ordy [3];
  logic [127:0] os [3];
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  mix_columns_unit #(.COLS_PER_CYCLE(1)) u1 (.clk(clk), .rst(rst[0]), .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(md[0]),
    .in_state(is_[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(os[0]));
  mix_columns_unit #(.COLS_PER_CYCLE(2)) u2 (.clk(clk), .rst(rst[1]), .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(md[1]),
    .in_state(is_[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(os[1]));
  mix_columns_unit #(.COLS_PER_CYCLE(4)) u4 (.clk(clk), .rst(rst[2]), .in_valid(iv[2]), .in_ready(ir[2]), .in_mode(md[2]),
    .in_state(is_[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(os[2]));
  typedef struct {
    int           d;
    logic [1:0]   m;
    logic [127:0] s;
    logic [127:0] e;
    int           lat;
  } vec_t;
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction
  function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic [1:0] m);
    logic [7:0] fb [4] = '{8'h02, 8'h03, 8'h01, 8'h01};
    logic [7:0] ib [4] = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    logic [127:0] r = s;
    logic [7:0] acc;
    if (m[1]) return s;
    for (int c = 0; c < 4; c++)
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc ^= gmul(m[0] ? ib[(k - row + 4) % 4] : fb[(k - row + 4) % 4], s[c*32 + 24 - 8*k +: 8]);
        r[c*32 + 24 - 8*row +: 8] = acc;
      end
    return r;
  endfunction
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run(input int d, input logic [1:0] m, input logic [127:0] s, output logic [127:0] r, output int lat);
    int n = 0;
    iv[d] = 1; md[d] = m; is_[d] = s;
    while (!ir[d] && n < 20) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    iv[d] = 0; md[d] = 2'($urandom); is_[d] = rnd128();
    lat = 0;
    while (!ov[d] && lat < 20) begin @(posedge clk); #1; lat++; end
    r = os[d];
    @(posedge clk); #1;
  endtask
  initial begin
    vec_t vt [6];
    logic [127:0] r, r2, a, b;
    int lat;
    vt[0] = '{2, 2'b00, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1};
    vt[1] = '{0, 2'b01, 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8, 128'hdb135345_f20a225c_d4d4d4d5_2d26314c, 4};
    vt[2] = '{1, 2'b10, 128'h01234567_89abcdef_fedcba98_76543210, 128'h01234567_89abcdef_fedcba98_76543210, 2};
    vt[3] = '{1, 2'b11, 128'h01234567_89abcdef_fedcba98_76543210, 128'h01234567_89abcdef_fedcba98_76543210, 2};
    vt[4] = '{1, 2'b00, 128'hdb135345_f20a225c_01010101_c6c6c6c6, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 2};
    vt[5] = '{0, 2'b00, 128'hd4d4d4d5_2d26314c_01010101_c6c6c6c6, 128'hd5d5d7d6_4d7ebdf8_01010101_c6c6c6c6, 4};
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1; iv[d] = 0; md[d] = 0; is_[d] = 0; ordy[d] = 1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_in_ready_d%0d", d), 128'(ir[d]), 128'(0));
      chk($sformatf("reset_out_valid_d%0d", d), 128'(ov[d]), 128'(0));
      chk($sformatf("reset_out_state_d%0d", d), os[d], 128'(0));
      rst[d] = 0;
    end
    #1;
    for (int d = 0; d < 3; d++) chk($sformatf("idle_in_ready_d%0d", d), 128'(ir[d]), 128'(1));
    for (int i = 0; i < 6; i++) begin
      run(vt[i].d, vt[i].m, vt[i].s, r, lat);
      chk($sformatf("vec%0d_state", i), r, vt[i].e);
      chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(vt[i].lat));
    end
    for (int i = 0; i < 100; i++) begin
      a = rnd128();
      run(i % 3, 2'b00, a, r, lat);
      chk($sformatf("rand%0d_fwd", i), r, ref_mix(a, 2'b00));
      run((i + 1) % 3, 2'b01, r, r2, lat);
      chk($sformatf("rand%0d_roundtrip", i), r2, a);
      chk($sformatf("rand%0d_inv_latency", i), 128'(lat), 128'(4 >> ((i + 1) % 3)));
    end
    for (int i = 0; i < 12; i++) begin
      a = rnd128();
      run(i % 3, 2'(i % 4), a, r, lat);
      chk($sformatf("mode%0d_d%0d_state", i % 4, i % 3), r, ref_mix(a, 2'(i % 4)));
      chk($sformatf("mode%0d_d%0d_latency", i % 4, i % 3), 128'(lat), 128'(4 >> (i % 3)));
    end
    a = rnd128(); b = rnd128();
    ordy[2] = 0; iv[2] = 1; md[2] = 2'b00; is_[2] = a;
    @(posedge clk); #1;
    iv[2] = 0; is_[2] = rnd128();
    @(posedge clk); #1;
    chk("bp_first_valid", 128'(ov[2]), 128'(1));
    chk("bp_first_state", os[2], ref_mix(a, 2'b00));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_valid", i), 128'(ov[2]), 128'(1));
      chk($sformatf("bp_hold%0d_state", i), os[2], ref_mix(a, 2'b00));
      chk($sformatf("bp_hold%0d_in_ready", i), 128'(ir[2]), 128'(0));
    end
    ordy[2] = 1; iv[2] = 1; md[2] = 2'b01; is_[2] = b;
    #1;
    chk("b2b_in_ready", 128'(ir[2]), 128'(1));
    @(posedge clk); #1;
    iv[2] = 0; is_[2] = rnd128(); md[2] = 2'b00;
    chk("b2b_busy_valid", 128'(ov[2]), 128'(0));
    chk("b2b_busy_in_ready", 128'(ir[2]), 128'(0));
    @(posedge clk); #1;
    chk("b2b_second_valid", 128'(ov[2]), 128'(1));
    chk("b2b_second_state", os[2], ref_mix(b, 2'b01));
    @(posedge clk); #1;
    iv[0] = 1; md[0] = 2'b00; is_[0] = rnd128();
    @(posedge clk); #1;
    iv[0] = 0;
    @(posedge clk); #1;
    rst[0] = 1;
    @(posedge clk); #1;
    rst[0] = 0;
    #1;
    chk("midrst_out_valid", 128'(ov[0]), 128'(0));
    chk("midrst_out_state", os[0], 128'(0));
    chk("midrst_in_ready", 128'(ir[0]), 128'(1));
    repeat (5) begin
      @(posedge clk); #1;
      chk("midrst_no_stale_valid", 128'(ov[0]), 128'(0));
    end
    a = rnd128();
    run(0, 2'b01, a, r, lat);
    chk("midrst_next_state", r, ref_mix(a, 2'b01));
    chk("midrst_next_latency", 128'(lat), 128'(4));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
